// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding, register addresses and
// baud-tick sample points used by both the receiver and the transmitter.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;

    localparam logic [1:0] SPART_ADDR_DATA   = 2'b00;
    localparam logic [1:0] SPART_ADDR_STATUS = 2'b01;

    // Sample points in 16x-baud ticks: half a bit into the start bit, then one full bit apart.
    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_BIT   = 4'd15;

endpackage

// File: rtl/spart_sync.sv
// Multi-flop synchroniser for an asynchronous level input; every flop
// resets to 1 so an idle-high serial line never looks like a start edge.
module spart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic synced
);

    logic [STAGES-1:0] flops;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flops <= '1;
        end else begin
            flops <= {flops[STAGES-2:0], raw};
        end
    end

    assign synced = flops[STAGES-1];

endmodule

// File: rtl/spart_rx2.sv
// SPART receiver: deserialises 8N1 frames sampled on the 16x-baud enable,
// holds the byte for the databus and reports RDA, framing and overrun status.
module spart_rx2
    import spart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] addr,
    input  logic       iorw,
    input  logic       iocs,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       RDA,
    output logic       FE,
    output logic       OE
);

    rx_state_t   state;
    rx_state_t   next_state;
    logic        rx_s;
    logic [3:0]  baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        shift_en;
    logic        load;
    logic        data_read;
    logic        status_read;

    spart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (RX),
        .synced (rx_s)
    );

    assign data_read   = iocs & iorw & (addr == SPART_ADDR_DATA);
    assign status_read = iocs & iorw & (addr == SPART_ADDR_STATUS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) next_state = START;
            end
            START: begin
                // A start bit that is gone by mid-bit is treated as line noise.
                if (enable && baud_cnt == MID_START) next_state = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (enable && baud_cnt == MID_BIT) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) next_state = STOP;
                end
            end
            STOP: begin
                if (enable && baud_cnt == MID_BIT) begin
                    load       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
        end else begin
            if (state == IDLE) begin
                baud_cnt <= 4'd0;
            end else if (state == START && enable && baud_cnt == MID_START) begin
                baud_cnt <= 4'd0;
            end else if (enable) begin
                baud_cnt <= baud_cnt + 4'd1;
            end

            if (state == START) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // LSB arrives first, so each new bit enters at the top.
    always_ff @(posedge clk) begin
        if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data <= 8'h00;
            RDA     <= 1'b0;
            FE      <= 1'b0;
            OE      <= 1'b0;
        end else begin
            if (load) rx_data <= shift_reg;

            if (load) begin
                RDA <= 1'b1;
            end else if (data_read) begin
                RDA <= 1'b0;
            end

            // Fresh error events are OR-ed in after the clear so they are never lost.
            FE <= (FE & ~status_read) | (load & ~rx_s);
            OE <= (OE & ~status_read) | (load & RDA & ~data_read);
        end
    end

endmodule

// File: tb/tb_spart_rx2.sv
// Directed bench for spart_rx2: enable every 4 clks gives 64 clks per bit.
module tb_spart_rx2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] addr;
    logic       iorw;
    logic       iocs;
    logic       RX;
    logic [7:0] rx_data;
    logic       RDA;
    logic       FE;
    logic       OE;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    logic [7:0] b2b [4] = '{8'h00, 8'hFF, 8'h55, 8'hAA};

    spart_rx2 #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .addr    (addr),
        .iorw    (iorw),
        .iocs    (iocs),
        .RX      (RX),
        .rx_data (rx_data),
        .RDA     (RDA),
        .FE      (FE),
        .OE      (OE)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign enable = (cyc % 4 == 3);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a);
        addr = a;
        iocs = 1'b1;
        iorw = 1'b1;
        @(negedge clk);
        iocs = 1'b0;
        iorw = 1'b0;
    endtask

    // Start bit is launched so an enable lands on the first clock edge that sees it;
    // the load edge is then exactly 608 clocks later (32 clocks into the stop bit).
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input bit rd_at_load, input bit chk_lat, input int abort_bit);
        @(negedge clk);
        while (enable !== 1'b1) @(negedge clk);
        RX = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                rst_n = 1'b0;
                RX    = 1'b1;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            RX = d[i];
            repeat (64) @(negedge clk);
        end
        RX = stop_val;
        for (int k = 0; k < 64; k++) begin
            if (k == 32) begin
                if (chk_lat) chk("rda_before_load", RDA, 1'b0);
                if (rd_at_load) begin
                    addr = 2'b00;
                    iocs = 1'b1;
                    iorw = 1'b1;
                end
            end
            if (k == 33) begin
                if (chk_lat) chk("rda_at_load_edge", RDA, 1'b1);
                iocs = 1'b0;
                iorw = 1'b0;
            end
            if (k == 44 && stop_val == 1'b0) RX = 1'b1;
            @(negedge clk);
        end
        RX = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        RX    = 1'b1;
        iocs  = 1'b0;
        iorw  = 1'b0;
        addr  = 2'b00;
        tick(4);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rda", RDA, 1'b0);
        chk("reset_fe", FE, 1'b0);
        chk("reset_oe", OE, 1'b0);
        rst_n = 1'b1;
        tick(10);

        // Good frame, exact load latency, write ignored, then data read
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
        tick(4);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_rda", RDA, 1'b1);
        chk("a5_fe", FE, 1'b0);
        chk("a5_oe", OE, 1'b0);
        addr = 2'b00; iocs = 1'b1; iorw = 1'b0;
        tick(1);
        iocs = 1'b0;
        tick(1);
        chk("write_ignored_rda", RDA, 1'b1);
        bus_read(2'b00);
        tick(1);
        chk("a5_read_rda", RDA, 1'b0);
        chk("a5_read_hold", rx_data, 8'hA5);

        // Short low pulse on RX
        tick(8);
        RX = 1'b0;
        tick(20);
        RX = 1'b1;
        tick(100);
        chk("glitch_rda", RDA, 1'b0);
        chk("glitch_fe", FE, 1'b0);
        chk("glitch_oe", OE, 1'b0);
        chk("glitch_data", rx_data, 8'hA5);

        // Bad stop bit
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        tick(4);
        chk("3c_data", rx_data, 8'h3C);
        chk("3c_rda", RDA, 1'b1);
        chk("3c_fe", FE, 1'b1);
        chk("3c_oe", OE, 1'b0);
        bus_read(2'b01);
        tick(1);
        chk("3c_fe_cleared", FE, 1'b0);
        chk("3c_rda_kept", RDA, 1'b1);
        bus_read(2'b00);
        tick(1);
        chk("3c_rda_cleared", RDA, 1'b0);
        tick(60);
        chk("3c_no_extra_load", RDA, 1'b0);

        // Overrun
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
        tick(4);
        chk("ovr_data", rx_data, 8'h22);
        chk("ovr_oe", OE, 1'b1);
        chk("ovr_rda", RDA, 1'b1);
        chk("ovr_fe", FE, 1'b0);
        bus_read(2'b01);
        tick(1);
        chk("ovr_oe_cleared", OE, 1'b0);

        // Read coinciding with load
        send_frame(8'h11, 1'b1, 1'b1, 0, -1);
        tick(2);
        chk("rdload1_data", rx_data, 8'h11);
        chk("rdload1_oe", OE, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 0, -1);
        tick(4);
        chk("rdload2_data", rx_data, 8'h22);
        chk("rdload2_rda", RDA, 1'b1);
        chk("rdload2_oe", OE, 1'b0);
        bus_read(2'b00);
        tick(1);

        // Reset in the middle of a frame
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 4);
        tick(4);
        chk("abort_data", rx_data, 8'h00);
        chk("abort_rda", RDA, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
        tick(4);
        chk("5a_data", rx_data, 8'h5A);
        chk("5a_rda", RDA, 1'b1);
        chk("5a_fe", FE, 1'b0);
        chk("5a_oe", OE, 1'b0);
        bus_read(2'b00);

        // Back-to-back frames, each read before the next one lands
        for (int i = 0; i < 4; i++) begin
            send_frame(b2b[i], 1'b1, 1'b0, 1'b0, -1);
            chk("b2b_data", rx_data, b2b[i]);
            chk("b2b_rda", RDA, 1'b1);
            bus_read(2'b00);
        end
        tick(2);
        chk("b2b_fe", FE, 1'b0);
        chk("b2b_oe", OE, 1'b0);
        chk("b2b_rda_final", RDA, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
